// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of DEPTH pipeline latches carrying a
// control and a data field. Each stage has its own valid bit and the
// valid/ready handshake runs through the whole chain. Empty stages always
// accept, so bubbles collapse while the chain is stalled. Bubbles carry an
// all-zero control field so downstream write enables never fire spuriously.

// One register stage: valid, control, data.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_adv,
  input  logic              i_v,
  input  logic [CTRL_W-1:0] i_c,
  input  logic [DATA_W-1:0] i_d,
  output logic              o_v,
  output logic [CTRL_W-1:0] o_c,
  output logic [DATA_W-1:0] o_d
);
  logic              r_v;
  logic [CTRL_W-1:0] r_c;
  logic [DATA_W-1:0] r_d;

  // Valid and control: cleared by reset/flush, zeroed when a bubble loads.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_v <= 1'b0;
      r_c <= '0;
    end else if (i_adv) begin
      r_v <= i_v;
      r_c <= i_v ? i_c : '0;
    end
  end

  // Data has no reset; its value is meaningless while the stage is empty.
  always_ff @(posedge clk) begin
    if (i_adv) r_d <= i_d;
  end

  assign o_v = r_v;
  assign o_c = r_c;
  assign o_d = r_d;
endmodule

module pipe_stage_chain #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0]             w_v;
  logic [DEPTH-1:0][CTRL_W-1:0] w_c;
  logic [DEPTH-1:0][DATA_W-1:0] w_d;
  logic [DEPTH-1:0]             w_src_v;
  logic [DEPTH-1:0][CTRL_W-1:0] w_src_c;
  logic [DEPTH-1:0][DATA_W-1:0] w_src_d;
  logic [DEPTH-1:0]             w_adv;
  logic [OCC_W-1:0]             w_occ;

  // Advance terms, rippling from the output back to the input. A running
  // carry keeps this a plain chain rather than a vector feeding itself.
  always_comb begin
    logic carry;
    carry = out_ready;
    w_adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      carry    = !w_v[i] | carry;
      w_adv[i] = carry;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_src_v[g] = in_valid;
      assign w_src_c[g] = in_ctrl;
      assign w_src_d[g] = in_data;
    end else begin : g_body
      assign w_src_v[g] = w_v[g-1];
      assign w_src_c[g] = w_c[g-1];
      assign w_src_d[g] = w_d[g-1];
    end

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .i_adv (w_adv[g]),
      .i_v   (w_src_v[g]),
      .i_c   (w_src_c[g]),
      .i_d   (w_src_d[g]),
      .o_v   (w_v[g]),
      .o_c   (w_c[g]),
      .o_d   (w_d[g])
    );
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) w_occ = w_occ + OCC_W'(w_v[i]);
  end

  // Flush drops the incoming beat, so upstream is always released then.
  assign in_ready  = w_adv[0] | flush;
  assign out_valid = w_v[DEPTH-1];
  assign out_ctrl  = w_c[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign occupancy = w_occ;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: DEPTH=3, 4 and 1 instances share stimulus;
// one is selected per phase and its outputs are checked against a scoreboard.
module tb_pipe_stage_chain;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [7:0]  oc_a, oc_b, oc_c;
  logic [63:0] od_a, od_b, od_c;
  logic [1:0]  occ_a;
  logic [2:0]  occ_b;
  logic [0:0]  occ_c;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(64), .CTRL_W(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(ov_a), .out_ready(out_ready),
    .out_ctrl(oc_a), .out_data(od_a), .occupancy(occ_a));
  pipe_stage_chain #(.DATA_W(64), .CTRL_W(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(ov_b), .out_ready(out_ready),
    .out_ctrl(oc_b), .out_data(od_b), .occupancy(occ_b));
  pipe_stage_chain #(.DATA_W(64), .CTRL_W(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(ov_c), .out_ready(out_ready),
    .out_ctrl(oc_c), .out_data(od_c), .occupancy(occ_c));

  typedef struct { logic [7:0] c; logic [63:0] d; } beat_t;
  beat_t sb[$];

  int tests = 0, fails = 0, popped = 0;
  int sel = 0;

  logic        m_ir, m_ov;
  logic [7:0]  m_oc;
  logic [63:0] m_od;
  int          m_occ;

  always_comb begin
    m_ir = ir_a; m_ov = ov_a; m_oc = oc_a; m_od = od_a; m_occ = int'(occ_a);
    case (sel)
      1: begin m_ir = ir_b; m_ov = ov_b; m_oc = oc_b; m_od = od_b; m_occ = int'(occ_b); end
      2: begin m_ir = ir_c; m_ov = ov_c; m_oc = oc_c; m_od = od_c; m_occ = int'(occ_c); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: push accepted beats, pop and compare consumed beats.
  always @(negedge clk) begin
    if (rst === 1'b1) sb.delete();
    else begin
      if (m_ov === 1'b1 && out_ready) begin
        tests++;
        assert (sb.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_beat: got out_data %0h, expected no beat", m_od);
        end
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", m_od, e.d);
          chk("out_ctrl", {56'd0, m_oc}, {56'd0, e.c});
          popped++;
        end
      end
      if (m_ov === 1'b0) chk("bubble_ctrl_zero", {56'd0, m_oc}, 64'd0);
      if (flush) sb.delete();
      else if (in_valid && m_ir === 1'b1) begin
        beat_t b;
        b.c = in_ctrl; b.d = in_data;
        sb.push_back(b);
      end
    end
  end

  initial begin
    int first, last, nv, idx, nout, p0;
    logic [5:0]  pat;
    logic        got, stall_prev;
    logic [63:0] prev_d;

    // Reset with in_valid held high
    rst = 1; in_valid = 1; in_ctrl = 8'hAA; in_data = 64'h1234; flush = 0; out_ready = 1;
    sel = 0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out_valid", {63'd0, m_ov}, 64'd0);
      chk("rst_out_ctrl", {56'd0, m_oc}, 64'd0);
      chk("rst_occupancy", 64'(m_occ), 64'd0);
      cyc();
    end
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, m_ir}, 64'd1);
    cyc();

    // Stream 1..10, DEPTH=3, out_ready=1
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (i < 10) begin in_valid = 1; in_ctrl = 8'h05; in_data = 64'(i + 1); end
      else in_valid = 0;
      @(negedge clk);
      if (m_ov === 1'b1) begin if (first < 0) first = i; last = i; nv++; end
      cyc();
    end
    chk("stream_latency", 64'(first), 64'd3);
    chk("stream_last_cycle", 64'(last), 64'd12);
    chk("stream_count", 64'(nv), 64'd10);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Bubble collapse: A, gap, B, C under stall, then D
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h11; in_data = 64'hA; cyc();
    in_valid = 0; cyc();
    in_valid = 1; in_ctrl = 8'h22; in_data = 64'hB; cyc();
    in_ctrl = 8'h33; in_data = 64'hC; cyc();
    in_ctrl = 8'h44; in_data = 64'hD;
    @(negedge clk);
    chk("bub_occ_full", 64'(m_occ), 64'd3);
    chk("bub_in_ready_low", {63'd0, m_ir}, 64'd0);
    cyc();
    out_ready = 1;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("bub_in_ready_release", {63'd0, m_ir}, 64'd1);
      pat = {pat[4:0], m_ov === 1'b1};
      cyc();
      in_valid = 0;
    end
    chk("bub_no_gaps", {58'd0, pat}, 64'b111100);
    chk("bub_drained", 64'(sb.size()), 64'd0);

    // Flush with 3 beats held, DEPTH=4
    sel = 1; rst = 1; in_valid = 0; cyc(); rst = 0;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_ctrl = 8'h30 + 8'(i); in_data = 64'h300 + 64'(i); cyc();
    end
    flush = 1; in_valid = 1; in_ctrl = 8'hEE; in_data = 64'hDEAD;
    @(negedge clk);
    chk("flush_occ_before", 64'(m_occ), 64'd3);
    chk("flush_in_ready", {63'd0, m_ir}, 64'd1);
    cyc();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_occ_after", 64'(m_occ), 64'd0);
    chk("flush_out_valid", {63'd0, m_ov}, 64'd0);
    chk("flush_out_ctrl", {56'd0, m_oc}, 64'd0);
    out_ready = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("flush_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in the same cycle as an output consume
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h5E; in_data = 64'hE; cyc();
    in_ctrl = 8'h5F; in_data = 64'hF; cyc();
    in_valid = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (m_ov === 1'b1) got = 1;
      else cyc();
    end
    chk("fc_reached_output", {63'd0, got}, 64'd1);
    cyc();
    p0 = popped;
    out_ready = 1; flush = 1;
    cyc();
    flush = 0; out_ready = 0;
    @(negedge clk);
    chk("fc_consumed", 64'(popped - p0), 64'd1);
    chk("fc_occ", 64'(m_occ), 64'd0);
    chk("fc_out_valid", {63'd0, m_ov}, 64'd0);
    cyc();
    chk("fc_sb_empty", 64'(sb.size()), 64'd0);

    // DEPTH=1 with out_ready toggling each cycle
    sel = 2; rst = 1; in_valid = 0; cyc(); rst = 0;
    idx = 0; first = -1; last = -1; nout = 0; stall_prev = 0; prev_d = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2) == 1;
      in_valid  = idx < 8;
      in_ctrl   = 8'h77;
      in_data   = 64'h10 + 64'(idx);
      @(negedge clk);
      if (stall_prev) chk("d1_hold_data", m_od, prev_d);
      stall_prev = (m_ov === 1'b1) && !out_ready;
      prev_d = m_od;
      if (m_ov === 1'b1 && out_ready) begin if (first < 0) first = c; last = c; nout++; end
      if (in_valid && m_ir === 1'b1) idx++;
      cyc();
    end
    chk("d1_beats", 64'(nout), 64'd8);
    chk("d1_rate", 64'(last - first), 64'd14);
    chk("d1_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
